// File: rtl/mem_port_arbiter.sv
// Arbitrates one external memory bus between the fetch (IF) and load/store (MEM) ports.
// Only one bus transaction is outstanding at a time; MEM has priority with starvation relief for IF.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  input  logic                if_kill,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                mem_req_valid,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_we,
  input  logic [DATA_W-1:0]   mem_req_wdata,
  input  logic [DATA_W/8-1:0] mem_req_wstrb,
  output logic                mem_req_ready,
  output logic                mem_resp_valid,
  output logic [DATA_W-1:0]   mem_resp_data,
  output logic                bus_req_valid,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic                bus_req_we,
  output logic [DATA_W-1:0]   bus_req_wdata,
  output logic [DATA_W/8-1:0] bus_req_wstrb,
  input  logic                bus_req_ready,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_resp_data,
  output logic                busy
);

  // state   | meaning
  // ST_IDLE | no transaction outstanding; arbitrate IF/MEM requests
  // ST_ADDR | bus_req_valid asserted, waiting for bus_req_ready
  // ST_RESP | request accepted by bus, waiting for bus_resp_valid

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_mem_q, owner_mem_d;
  logic                killed_q, killed_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0]   bus_req_addr_q, bus_req_addr_d;
  logic                bus_req_we_q, bus_req_we_d;
  logic [DATA_W-1:0]   bus_req_wdata_q, bus_req_wdata_d;
  logic [STRB_W-1:0]   bus_req_wstrb_q, bus_req_wstrb_d;
  logic                if_resp_valid_q, if_resp_valid_d;
  logic [DATA_W-1:0]   if_resp_data_q, if_resp_data_d;
  logic                mem_resp_valid_q, mem_resp_valid_d;
  logic [DATA_W-1:0]   mem_resp_data_q, mem_resp_data_d;

  logic ifc;
  logic grant_if;
  logic grant_mem;

  // A killed fetch never competes for the bus.
  always_comb begin
    ifc       = if_req_valid & ~if_kill;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state_q == ST_IDLE) begin
      if (mem_req_valid && ifc) begin
        grant_if  = (starve_cnt_q == STARVE_MAX);
        grant_mem = (starve_cnt_q != STARVE_MAX);
      end else begin
        grant_if  = ifc;
        grant_mem = mem_req_valid;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_mem_d      = owner_mem_q;
    killed_d         = killed_q;
    starve_cnt_d     = starve_cnt_q;
    bus_req_addr_d   = bus_req_addr_q;
    bus_req_we_d     = bus_req_we_q;
    bus_req_wdata_d  = bus_req_wdata_q;
    bus_req_wstrb_d  = bus_req_wstrb_q;
    if_resp_valid_d  = 1'b0;
    if_resp_data_d   = if_resp_data_q;
    mem_resp_valid_d = 1'b0;
    mem_resp_data_d  = mem_resp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (!ifc) begin
          starve_cnt_d = '0;
        end
        if (grant_if) begin
          bus_req_addr_d  = if_req_addr;
          bus_req_we_d    = 1'b0;
          bus_req_wdata_d = '0;
          bus_req_wstrb_d = '0;
          owner_mem_d     = 1'b0;
          killed_d        = 1'b0;
          starve_cnt_d    = '0;
          state_d         = ST_ADDR;
        end else if (grant_mem) begin
          bus_req_addr_d  = mem_req_addr;
          bus_req_we_d    = mem_req_we;
          bus_req_wdata_d = mem_req_wdata;
          bus_req_wstrb_d = mem_req_wstrb;
          owner_mem_d     = 1'b1;
          killed_d        = 1'b0;
          if (ifc && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (!owner_mem_q && if_kill) begin
          killed_d = 1'b1;
        end
        if (bus_req_ready) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (!owner_mem_q && if_kill) begin
          killed_d = 1'b1;
        end
        if (bus_resp_valid) begin
          state_d = ST_IDLE;
          if (owner_mem_q) begin
            mem_resp_valid_d = 1'b1;
            mem_resp_data_d  = bus_req_we_q ? '0 : bus_resp_data;
          end else if (!(killed_q || if_kill)) begin
            // A kill arriving with the response still drops it.
            if_resp_valid_d = 1'b1;
            if_resp_data_d  = bus_resp_data;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      owner_mem_q      <= 1'b0;
      killed_q         <= 1'b0;
      starve_cnt_q     <= '0;
      bus_req_addr_q   <= '0;
      bus_req_we_q     <= 1'b0;
      bus_req_wdata_q  <= '0;
      bus_req_wstrb_q  <= '0;
      if_resp_valid_q  <= 1'b0;
      if_resp_data_q   <= '0;
      mem_resp_valid_q <= 1'b0;
      mem_resp_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      owner_mem_q      <= owner_mem_d;
      killed_q         <= killed_d;
      starve_cnt_q     <= starve_cnt_d;
      bus_req_addr_q   <= bus_req_addr_d;
      bus_req_we_q     <= bus_req_we_d;
      bus_req_wdata_q  <= bus_req_wdata_d;
      bus_req_wstrb_q  <= bus_req_wstrb_d;
      if_resp_valid_q  <= if_resp_valid_d;
      if_resp_data_q   <= if_resp_data_d;
      mem_resp_valid_q <= mem_resp_valid_d;
      mem_resp_data_q  <= mem_resp_data_d;
    end
  end

  assign if_req_ready   = grant_if;
  assign mem_req_ready  = grant_mem;
  assign if_resp_valid  = if_resp_valid_q;
  assign if_resp_data   = if_resp_data_q;
  assign mem_resp_valid = mem_resp_valid_q;
  assign mem_resp_data  = mem_resp_data_q;
  assign bus_req_valid  = (state_q == ST_ADDR);
  assign bus_req_addr   = bus_req_addr_q;
  assign bus_req_we     = bus_req_we_q;
  assign bus_req_wdata  = bus_req_wdata_q;
  assign bus_req_wstrb  = bus_req_wstrb_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).
- Provides a registered request/response handshake to each stage and keeps at most one transaction outstanding on the bus.
- Applies fixed priority (MEM over IF) with starvation protection for IF.
- Supports cancelling an in-flight fetch when the pipeline redirects; the transaction still completes on the bus, but its response is not delivered.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; must be a multiple of 8.
- STARVE_LIMIT, 4, consecutive MEM grants while IF waits before IF is forced to win (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_kill  in  1  cancel pending/in-flight fetch (pipeline redirect).
- if_resp_valid  out  1  fetch data valid; 1-cycle pulse.
- if_resp_data  out  DATA_W  fetch data.
- mem_req_valid  in  1  data request.
- mem_req_addr  in  ADDR_W  data address.
- mem_req_we  in  1  1 = store.
- mem_req_wdata  in  DATA_W  store data.
- mem_req_wstrb  in  DATA_W/8  byte enables.
- mem_req_ready  out  1  data request accepted this cycle.
- mem_resp_valid  out  1  data response; 1-cycle pulse; also pulses for stores.
- mem_resp_data  out  DATA_W  load data; 0 for stores.
- bus_req_valid  out  1  bus request.
- bus_req_addr  out  ADDR_W  bus address.
- bus_req_we  out  1  bus write.
- bus_req_wdata  out  DATA_W  bus write data.
- bus_req_wstrb  out  DATA_W/8  bus byte enables.
- bus_req_ready  in  1  bus accepted request.
- bus_resp_valid  in  1  bus response.
- bus_resp_data  in  DATA_W  bus read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low, async):
  - state = IDLE.
  - All valid/ready outputs 0.
  - All data/addr/strb outputs 0.
  - Starvation counter 0; owner = IF; killed = 0.
- FSM states: IDLE, ADDR, RESP.
- IDLE, grant selection (combinational):
  - ifc = if_req_valid & ~if_kill.
  - If mem_req_valid & ifc: MEM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - Single requester wins alone.
  - Only the winner's req_ready = 1. Both ready outputs are 0 outside IDLE.
- IDLE, on a handshake (winner valid & ready):
  - Latch addr/we/wdata/wstrb into the bus_req_* registers; IF requests latch we = 0, wstrb = 0.
  - Record owner; clear killed; go to ADDR.
- ADDR:
  - bus_req_valid = 1; all bus_req_* fields held stable until bus_req_ready.
  - On bus_req_ready, go to RESP and drop bus_req_valid next cycle.
- RESP:
  - Wait for bus_resp_valid, with no timeout.
  - On bus_resp_valid: the owner's resp_valid = 1 the next cycle, with data registered from bus_resp_data; state returns to IDLE on the same edge.
  - A new request may therefore be accepted in the cycle the response pulse is visible.
- bus_resp_valid outside RESP is ignored. The response arrives at the earliest one cycle after the bus_req_ready cycle.
- Minimum latency: handshake cycle t → bus_req_valid at t+1 → response pulse at t+3, when bus_req_ready is at t+1 and bus_resp_valid is at t+2.
- if_kill:
  - In ADDR/RESP with owner = IF, set killed. The bus transaction completes normally, and the matching if_resp_valid is suppressed.
  - if_kill in the same cycle as bus_resp_valid also suppresses.
  - MEM transactions are never affected by if_kill.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each MEM handshake in a cycle where ifc = 1.
  - Clears on an IF handshake, or in any IDLE cycle with ifc = 0.
- Data outputs (resp_data) hold their last value between pulses; resp_valid is never high for two consecutive cycles.

Test Plan:
- IF fetch, addr 0x1000, no MEM traffic, bus_req_ready at t+1, bus_resp_valid at t+2 with 0xDEAD_BEEF → bus_req_addr = 0x1000 and we = 0 at t+1; if_resp_valid = 1 with data 0xDEAD_BEEF at t+3; if_req_ready high again at t+3.
- Simultaneous IF 0x2000 and MEM store 0x8000/wdata 0x55/wstrb 0x01, starve_cnt = 0 → mem_req_ready = 1 and if_req_ready = 0; bus_req_we = 1 with the store fields; the store gets mem_resp_valid with data 0; IF is served next.
- MEM requesting every cycle with IF held valid → 4 consecutive MEM grants, then IF granted on the 5th arbitration; counter returns to 0.
- Backpressure: bus_req_ready low for 5 cycles in ADDR → bus_req_valid and all bus_req_* fields stable for all 5 cycles; no ready asserted to either requester.
- if_kill pulsed in RESP for an IF fetch → bus completes; if_resp_valid stays 0; next MEM request accepted as soon as state returns to IDLE; a separate if_kill in IDLE with if_req_valid gives if_req_ready = 0.
- rst asserted low in RESP → busy, bus_req_valid and resp_valid go 0 immediately; after release, an IF fetch completes with normal latency and a stale bus_resp_valid is ignored.
